// File: rtl/sdcard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdcard_pkg
// Description : Shared types and constants for the cache-line / SD bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package sdcard_pkg;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    // Request command encoding (bit 0 of the command field)
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Default SD sector size in bytes
    localparam int DEFAULT_SECTOR_BYTES = 512;

endpackage
`default_nettype wire

// File: rtl/sdcard_line_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sdcard_line_shifter
// Description : Cache-line register with parallel load, DATA-wide shift-out
//               from the LSB end and DATA-wide shift-in at the MSB end.
// Revision    : 1.0 - initial release
// ============================================================================
module sdcard_line_shifter
    import sdcard_pkg::*;
#(
    parameter int WIDTH = DEFAULT_SECTOR_BYTES * 8,
    parameter int DATA  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_in_i,
    input  logic [DATA-1:0]  shift_in_data_i,
    input  logic             shift_out_i,
    output logic [WIDTH-1:0] line_o,
    output logic [DATA-1:0]  shift_out_data_o
);

    logic [WIDTH-1:0] line_q;
    logic [WIDTH-1:0] line_d;
    logic [WIDTH-1:0] w_shifted_in;
    logic [WIDTH-1:0] w_shifted_out;

    // A line of exactly one beat has no upper part to shift down
    if (WIDTH > DATA) begin : g_multi_beat
        assign w_shifted_in  = {shift_in_data_i, line_q[WIDTH-1:DATA]};
        assign w_shifted_out = {{DATA{1'b0}}, line_q[WIDTH-1:DATA]};
    end else begin : g_single_beat
        assign w_shifted_in  = shift_in_data_i;
        assign w_shifted_out = '0;
    end

    // Next line value: load beats shifting, and only one shift kind is used per request
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_data_i;
        end else if (shift_in_i) begin
            line_d = w_shifted_in;
        end else if (shift_out_i) begin
            line_d = w_shifted_out;
        end
    end

    // Line register
    always_ff @(posedge clock) begin
        if (reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o           = line_q;
    assign shift_out_data_o = line_q[DATA-1:0];

endmodule
`default_nettype wire

// File: rtl/sdcard_line_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sdcard_line_bridge
// Description : Turns each cache refill/writeback request into SECTORS
//               back-to-back SD sector transfers with a progress watchdog,
//               and answers every request with a response carrying an error
//               flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sdcard_line_bridge
    import sdcard_pkg::*;
#(
    parameter  int ADDR         = 32,
    parameter  int DATA         = 8,
    parameter  int CMD          = 1,
    parameter  int SECTOR_BYTES = DEFAULT_SECTOR_BYTES,
    parameter  int SECTORS      = 1,
    parameter  int TIMEOUT      = 65535,
    localparam int WIDTH        = SECTORS * SECTOR_BYTES * 8
) (
    input  logic             clock,
    input  logic             reset,
    // cache request side
    input  logic             sd_valid_out,
    output logic             sd_ready_out,
    input  logic [ADDR-1:0]  sd_addr_out,
    input  logic [WIDTH-1:0] sd_data_out,
    input  logic [CMD-1:0]   sd_cmd_out,
    // cache response side
    output logic             sd_valid_in,
    input  logic             sd_ready_in,
    output logic [WIDTH-1:0] sd_data_in,
    output logic             sd_err_in,
    // SD controller side
    output logic             rd,
    output logic             wr,
    input  logic [DATA-1:0]  dout,
    input  logic             dout_valid,
    output logic [DATA-1:0]  din,
    input  logic             din_ready,
    input  logic             ready,
    output logic [ADDR-1:0]  ain
);

    localparam int BEATS  = SECTOR_BYTES * 8 / DATA;
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam int SEC_W  = $clog2(SECTORS) + 1;
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam int SHIFT  = $clog2(SECTOR_BYTES);

    state_t            state_q,  state_d;
    logic [CMD-1:0]    cmd_q,    cmd_d;
    logic [ADDR-1:0]   ain_q,    ain_d;
    logic [SEC_W-1:0]  sector_q, sector_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [WDOG_W-1:0] wdog_q,   wdog_d;
    logic              err_q,    err_d;

    logic              w_is_wr;
    logic              w_beat;
    logic [WDOG_W-1:0] w_wdog_inc;
    logic              w_expire;
    logic              w_load;
    logic              w_shift_in;
    logic              w_shift_out;

    assign w_is_wr    = (cmd_q[0] == CMD_WR);
    assign w_beat     = w_is_wr ? din_ready : dout_valid;
    assign w_wdog_inc = wdog_q + 1'b1;
    assign w_expire   = (w_wdog_inc == WDOG_W'(TIMEOUT));

    // Next-state, counter and shifter-control decode
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ain_d       = ain_q;
        sector_d    = sector_q;
        beat_d      = beat_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        w_load      = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (sd_valid_out) begin
                    cmd_d    = sd_cmd_out;
                    ain_d    = sd_addr_out >> SHIFT;
                    sector_d = '0;
                    beat_d   = '0;
                    err_d    = 1'b0;
                    w_load   = (sd_cmd_out[0] == CMD_WR);
                    state_d  = REQ;
                end
            end

            REQ: begin
                if (ready) begin
                    // Controller acceptance counts as progress for the watchdog
                    beat_d  = '0;
                    wdog_d  = '0;
                    state_d = XFER;
                end else if (w_expire) begin
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = RESP;
                end else begin
                    wdog_d = w_wdog_inc;
                end
            end

            XFER: begin
                // A beat always wins over a simultaneous watchdog expiry
                if (w_beat) begin
                    wdog_d      = '0;
                    beat_d      = beat_q + 1'b1;
                    w_shift_in  = ~w_is_wr;
                    w_shift_out = w_is_wr;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        if (sector_q != SEC_W'(SECTORS - 1)) begin
                            ain_d    = ain_q + 1'b1;
                            sector_d = sector_q + 1'b1;
                            state_d  = REQ;
                        end else begin
                            state_d = RESP;
                        end
                    end
                end else if (w_expire) begin
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = RESP;
                end else begin
                    wdog_d = w_wdog_inc;
                end
            end

            RESP: begin
                wdog_d = '0;
                if (sd_ready_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            ain_q    <= '0;
            sector_q <= '0;
            beat_q   <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            ain_q    <= ain_d;
            sector_q <= sector_d;
            beat_q   <= beat_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    sdcard_line_shifter #(
        .WIDTH (WIDTH),
        .DATA  (DATA)
    ) u_line (
        .clock            (clock),
        .reset            (reset),
        .load_i           (w_load),
        .load_data_i      (sd_data_out),
        .shift_in_i       (w_shift_in),
        .shift_in_data_i  (dout),
        .shift_out_i      (w_shift_out),
        .line_o           (sd_data_in),
        .shift_out_data_o (din)
    );

    // All handshake outputs come straight from registers
    assign sd_ready_out = (state_q == IDLE);
    assign rd           = (state_q == REQ) && !w_is_wr;
    assign wr           = (state_q == REQ) &&  w_is_wr;
    assign sd_valid_in  = (state_q == RESP);
    assign sd_err_in    = err_q;
    assign ain          = ain_q;

endmodule
`default_nettype wire

// File: tb/tb_sdcard_line_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdcard_line_bridge
// Description : Self-checking bench for sdcard_line_bridge with a two-sector
//               line and a short watchdog, driven by a behavioural SD
//               controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdcard_line_bridge;

    localparam int ADDR       = 32;
    localparam int DATA       = 8;
    localparam int SB         = 512;
    localparam int SECTORS    = 2;
    localparam int TIMEOUT    = 16;
    localparam int WIDTH      = SECTORS * SB * 8;
    localparam int BEATS      = SB;
    localparam int LINE_BYTES = SECTORS * SB;
    localparam int ZW_LAT     = 1 + SECTORS * (1 + BEATS);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             sd_valid_out = 1'b0;
    logic             sd_ready_out;
    logic [ADDR-1:0]  sd_addr_out = '0;
    logic [WIDTH-1:0] sd_data_out = '0;
    logic [0:0]       sd_cmd_out = '0;
    logic             sd_valid_in;
    logic             sd_ready_in = 1'b0;
    logic [WIDTH-1:0] sd_data_in;
    logic             sd_err_in;
    logic             rd;
    logic             wr;
    logic [DATA-1:0]  dout = '0;
    logic             dout_valid = 1'b0;
    logic [DATA-1:0]  din;
    logic             din_ready = 1'b0;
    logic             ready = 1'b0;
    logic [ADDR-1:0]  ain;

    int vectors     = 0;
    int miscompares = 0;

    // Reference stimulus and observations of one transaction
    logic [7:0]       rbytes [LINE_BYTES];
    logic [WIDTH-1:0] wline;
    logic [7:0]       din_log [$];
    logic [ADDR-1:0]  ain_log [$];
    int               obs_lat;
    logic             obs_err;
    logic [WIDTH-1:0] obs_line;
    bit               obs_to;
    int               obs_rd;
    int               obs_wr;

    sdcard_line_bridge #(
        .ADDR         (ADDR),
        .DATA         (DATA),
        .CMD          (1),
        .SECTOR_BYTES (SB),
        .SECTORS      (SECTORS),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sd_valid_out (sd_valid_out),
        .sd_ready_out (sd_ready_out),
        .sd_addr_out  (sd_addr_out),
        .sd_data_out  (sd_data_out),
        .sd_cmd_out   (sd_cmd_out),
        .sd_valid_in  (sd_valid_in),
        .sd_ready_in  (sd_ready_in),
        .sd_data_in   (sd_data_in),
        .sd_err_in    (sd_err_in),
        .rd           (rd),
        .wr           (wr),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .din          (din),
        .din_ready    (din_ready),
        .ready        (ready),
        .ain          (ain)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Read stimulus bytes in SD delivery order: pattern 0 = k mod 256, else random
    task automatic fill_rd(input int pattern);
        for (int k = 0; k < LINE_BYTES; k++)
            rbytes[k] = (pattern == 0) ? 8'(k) : 8'($urandom);
    endtask

    task automatic fill_wr(input int pattern);
        for (int k = 0; k < LINE_BYTES; k++)
            wline[8*k +: 8] = (pattern == 0) ? 8'(k) : 8'($urandom);
    endtask

    // Model: byte k of the line is the k-th SD byte; returns first bad index or -1
    function automatic int first_bad_line(input logic [WIDTH-1:0] line);
        for (int k = 0; k < LINE_BYTES; k++)
            if (line[8*k +: 8] !== rbytes[k]) return k;
        return -1;
    endfunction

    function automatic int first_bad_din();
        if (din_log.size() != LINE_BYTES) return LINE_BYTES;
        for (int k = 0; k < LINE_BYTES; k++)
            if (din_log[k] !== wline[8*k +: 8]) return k;
        return -1;
    endfunction

    function automatic int bad_ain(input logic [ADDR-1:0] addr);
        if (ain_log.size() != SECTORS) return 1;
        for (int s = 0; s < SECTORS; s++)
            if (ain_log[s] !== (addr >> 9) + ADDR'(s)) return 1;
        return 0;
    endfunction

    // Issue one request and play the SD controller until the response appears.
    // mode: 0 zero-wait, 1 beat every other cycle, 2 random stalls,
    //       3 ready never given, 4 beats stop after five.
    // abort_beat >= 0 asserts reset once that many read beats were consumed.
    task automatic do_txn(input bit is_wr, input logic [ADDR-1:0] addr,
                          input int mode, input int abort_beat);
        int  rem = 0, idx = 0, rdy_run = 0, stl_run = 0;
        bit  prev_beat = 0, prev_acc = 0, done = 0, go;
        din_log.delete();
        ain_log.delete();
        obs_rd = 0; obs_wr = 0; obs_lat = -1; obs_err = 1'bx; obs_line = '0;
        sd_ready_in = 1'b0;
        @(negedge clock);
        sd_valid_out = 1'b1;
        sd_addr_out  = addr;
        sd_cmd_out   = is_wr;
        sd_data_out  = wline;
        @(negedge clock);
        sd_valid_out = 1'b0;
        sd_data_out  = '0;
        for (int cyc = 1; cyc < 6000 && !done; cyc++) begin
            if (prev_beat) begin idx++; rem--; end
            if (prev_acc) rem = BEATS;
            prev_beat = 0; prev_acc = 0;
            dout_valid = 1'b0; din_ready = 1'b0; ready = 1'b0;
            if (sd_valid_in) begin
                obs_lat = cyc; obs_err = sd_err_in; obs_line = sd_data_in; done = 1;
            end else if (abort_beat >= 0 && idx == abort_beat) begin
                reset = 1'b1; obs_lat = cyc; done = 1;
            end else begin
                if (rd || wr) begin
                    if (rd) obs_rd++;
                    if (wr) obs_wr++;
                    if (mode == 3) ready = 1'b0;
                    else if (mode == 2) ready = (rdy_run >= 4) || ($urandom_range(0, 1) == 1);
                    else ready = 1'b1;
                    rdy_run = ready ? 0 : rdy_run + 1;
                    if (ready) begin ain_log.push_back(ain); prev_acc = 1; end
                end
                if (rem > 0 && !(mode == 4 && idx >= 5)) begin
                    if (mode == 1) go = (cyc % 2 == 0);
                    else if (mode == 2) go = (stl_run >= 4) || ($urandom_range(0, 2) != 0);
                    else go = 1;
                    stl_run = go ? 0 : stl_run + 1;
                    if (go) begin
                        if (is_wr) begin din_ready = 1'b1; din_log.push_back(din); end
                        else begin dout_valid = 1'b1; dout = rbytes[idx]; end
                        prev_beat = 1;
                    end
                end
            end
            if (!done) @(negedge clock);
        end
        dout_valid = 1'b0; din_ready = 1'b0; ready = 1'b0;
        obs_to = !done;
    endtask

    task automatic ack();
        sd_ready_in = 1'b1;
        @(negedge clock);
        sd_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++; if ({sd_ready_out, rd, wr, sd_valid_in, sd_err_in} !== 5'b10000) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 10000", {sd_ready_out, rd, wr, sd_valid_in, sd_err_in}); end
        vectors++; if (ain !== '0) begin
            miscompares++; $display("FAIL reset_ain: got %08h want 00000000", ain); end
        vectors++; if (sd_data_in !== '0 || din !== '0) begin
            miscompares++; $display("FAIL reset_line: line or din not zero, din=%02h", din); end
        reset = 1'b0;
    endtask

    task automatic test_read_basic();
        int bad;
        fill_rd(0);
        do_txn(1'b0, 32'h0000_0400, 0, -1);
        vectors++; if (obs_to) begin
            miscompares++; $display("FAIL rd_done: no response within budget"); end
        vectors++; if (obs_lat !== ZW_LAT) begin
            miscompares++; $display("FAIL rd_latency: got %0d want %0d", obs_lat, ZW_LAT); end
        vectors++; if (obs_err !== 1'b0) begin
            miscompares++; $display("FAIL rd_err: got %b want 0", obs_err); end
        vectors++; if (obs_line[15:0] !== 16'h0100) begin
            miscompares++; $display("FAIL rd_first_bytes: got %04h want 0100", obs_line[15:0]); end
        bad = first_bad_line(obs_line);
        vectors++; if (bad >= 0) begin
            miscompares++; $display("FAIL rd_line: byte %0d got %02h want %02h", bad, obs_line[8*bad +: 8], rbytes[bad]); end
        vectors++; if (obs_rd !== SECTORS) begin
            miscompares++; $display("FAIL rd_pulses: got %0d want %0d", obs_rd, SECTORS); end
        vectors++; if (bad_ain(32'h0000_0400) != 0) begin
            miscompares++; $display("FAIL rd_ain: %0d requests, first %08h want 00000002", ain_log.size(), ain_log[0]); end
        ack();
    endtask

    task automatic test_write_basic();
        int bad;
        fill_wr(0);
        do_txn(1'b1, 32'h0000_1000, 1, -1);
        vectors++; if (obs_to || obs_err !== 1'b0) begin
            miscompares++; $display("FAIL wr_resp: timeout=%0d err=%b want 0/0", obs_to, obs_err); end
        vectors++; if (obs_wr !== SECTORS) begin
            miscompares++; $display("FAIL wr_pulses: got %0d want %0d", obs_wr, SECTORS); end
        vectors++; if (bad_ain(32'h0000_1000) != 0) begin
            miscompares++; $display("FAIL wr_ain: %0d requests, first %08h want 00000008", ain_log.size(), ain_log[0]); end
        bad = first_bad_din();
        vectors++; if (bad >= 0) begin
            miscompares++; $display("FAIL wr_din: %0d beats, first bad index %0d", din_log.size(), bad); end
        ack();
    endtask

    task automatic test_random();
        int bad;
        bit is_wr;
        logic [ADDR-1:0] addr;
        for (int t = 0; t < 4; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            addr  = $urandom & 32'hFFFF_FC00;
            if (is_wr) fill_wr(1); else fill_rd(1);
            do_txn(is_wr, addr, 2, -1);
            vectors++; if (obs_to || obs_err !== 1'b0) begin
                miscompares++; $display("FAIL rand_resp[%0d]: timeout=%0d err=%b want 0/0", t, obs_to, obs_err); end
            vectors++; if (bad_ain(addr) != 0) begin
                miscompares++; $display("FAIL rand_ain[%0d]: addr %08h, %0d requests", t, addr, ain_log.size()); end
            bad = is_wr ? first_bad_din() : first_bad_line(obs_line);
            vectors++; if (bad >= 0) begin
                miscompares++; $display("FAIL rand_data[%0d]: wr=%0d first bad byte %0d", t, is_wr, bad); end
            ack();
        end
    endtask

    task automatic test_timeout();
        int bad;
        fill_rd(1);
        do_txn(1'b0, 32'h0000_2000, 3, -1);
        vectors++; if (obs_lat !== TIMEOUT + 1 || obs_err !== 1'b1) begin
            miscompares++; $display("FAIL to_req: lat=%0d err=%b want %0d/1", obs_lat, obs_err, TIMEOUT + 1); end
        vectors++; if (obs_rd !== TIMEOUT) begin
            miscompares++; $display("FAIL to_req_rd: rd high %0d cycles want %0d", obs_rd, TIMEOUT); end
        ack();
        vectors++; if (sd_err_in !== 1'b1) begin
            miscompares++; $display("FAIL to_err_hold: got %b want 1", sd_err_in); end
        do_txn(1'b0, 32'h0000_2400, 4, -1);
        vectors++; if (obs_lat !== 2 + 5 + TIMEOUT || obs_err !== 1'b1) begin
            miscompares++; $display("FAIL to_xfer: lat=%0d err=%b want %0d/1", obs_lat, obs_err, 2 + 5 + TIMEOUT); end
        ack();
        fill_rd(1);
        do_txn(1'b0, 32'h0000_2800, 0, -1);
        bad = first_bad_line(obs_line);
        vectors++; if (obs_err !== 1'b0 || obs_lat !== ZW_LAT || bad >= 0) begin
            miscompares++; $display("FAIL to_recover: err=%b lat=%0d bad=%0d want 0/%0d/-1", obs_err, obs_lat, bad, ZW_LAT); end
        ack();
    endtask

    task automatic test_backpressure();
        int bad;
        fill_rd(1);
        do_txn(1'b0, 32'h0000_4C00, 0, -1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            bad = first_bad_line(sd_data_in);
            vectors++; if ({sd_valid_in, sd_ready_out, sd_err_in} !== 3'b100 || bad >= 0) begin
                miscompares++; $display("FAIL bp_hold[%0d]: valid/ready/err=%b want 100, bad byte %0d", c, {sd_valid_in, sd_ready_out, sd_err_in}, bad); end
        end
        ack();
    endtask

    task automatic test_spurious();
        int bad;
        logic [ADDR-1:0] exp_ain;
        fill_rd(1);
        do_txn(1'b0, 32'h0001_8000, 0, -1);
        exp_ain = (32'h0001_8000 >> 9) + ADDR'(SECTORS - 1);
        for (int c = 0; c < 5; c++) begin
            dout_valid = 1'b1; din_ready = 1'b1; dout = 8'($urandom);
            @(negedge clock);
        end
        dout_valid = 1'b0; din_ready = 1'b0;
        bad = first_bad_line(sd_data_in);
        vectors++; if (bad >= 0 || ain !== exp_ain || sd_valid_in !== 1'b1) begin
            miscompares++; $display("FAIL spur_resp: bad byte %0d ain %08h want %08h valid %b", bad, ain, exp_ain, sd_valid_in); end
        ack();
        for (int c = 0; c < 5; c++) begin
            dout_valid = 1'b1; din_ready = 1'b1; dout = 8'($urandom);
            @(negedge clock);
        end
        dout_valid = 1'b0; din_ready = 1'b0;
        bad = first_bad_line(sd_data_in);
        vectors++; if (bad >= 0 || ain !== exp_ain || sd_ready_out !== 1'b1 || din !== rbytes[0]) begin
            miscompares++; $display("FAIL spur_idle: bad byte %0d ain %08h want %08h ready %b din %02h", bad, ain, exp_ain, sd_ready_out, din); end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_rd(1);
        do_txn(1'b0, 32'h0000_8000, 0, 100);
        vectors++; if (obs_to) begin
            miscompares++; $display("FAIL rst_mid_reach: beat 100 never reached"); end
        @(negedge clock);
        vectors++; if ({sd_ready_out, rd, wr, sd_valid_in, sd_err_in} !== 5'b10000 || ain !== '0) begin
            miscompares++; $display("FAIL rst_mid_ctrl: got %b ain %08h want 10000 00000000", {sd_ready_out, rd, wr, sd_valid_in, sd_err_in}, ain); end
        vectors++; if (sd_data_in !== '0 || din !== '0) begin
            miscompares++; $display("FAIL rst_mid_line: line or din not zero, din=%02h", din); end
        reset = 1'b0;
        fill_rd(1);
        do_txn(1'b0, 32'h0000_C000, 0, -1);
        bad = first_bad_line(obs_line);
        vectors++; if (obs_to || obs_err !== 1'b0 || obs_lat !== ZW_LAT || bad >= 0) begin
            miscompares++; $display("FAIL rst_mid_read: err=%b lat=%0d bad=%0d want 0/%0d/-1", obs_err, obs_lat, bad, ZW_LAT); end
        ack();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_random();
        test_timeout();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdcard_line_bridge.md
# sdcard_line_bridge

Parametrised bridge between the cache refill/writeback port and the byte-stream SD controller. A cache line spans one or more consecutive SD sectors: each cache request becomes SECTORS back-to-back sector reads or writes, with a watchdog timeout. Every request, read or write, completes with a response that carries an error flag. It sits in the same place as the current glue: cache on one side, SD controller on the other.

## Interface
- ADDR, 32, byte address width of the cache request and width of the SD sector address `ain`
- DATA, 8, SD data bus width; multiple of 8, divides SECTOR_BYTES*8
- CMD, 1, command width; bit 0: 0 = read, 1 = write
- SECTOR_BYTES, 512, sector size; power of two
- SECTORS, 1, sectors per cache line; ≥1
- TIMEOUT, 65535, cycles without progress before abort; ≥2
- WIDTH (localparam) = SECTORS*SECTOR_BYTES*8, cache line width
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- sd_valid_out / sd_ready_out  in/out  1  cache request handshake
- sd_addr_out  in  ADDR  byte address, line-aligned
- sd_data_out  in  WIDTH  write line
- sd_cmd_out  in  CMD  request command
- sd_valid_in / sd_ready_in  out/in  1  response handshake
- sd_data_in  out  WIDTH  read line (valid when sd_valid_in & read)
- sd_err_in  out  1  response error flag (timeout)
- rd, wr  out  1  sector read/write request to SD controller
- dout / dout_valid  in  DATA/1  read beat
- din / din_ready  out/in  DATA/1  write beat; din_ready = beat consumed
- ready  in  1  controller accepts rd/wr
- ain  out  ADDR  sector address, registered

## Operation
- States: IDLE, REQ, XFER, RESP.
- IDLE: sd_ready_out=1. On sd_valid_out: latch cmd. Set ain = sd_addr_out >> log2(SECTOR_BYTES) and sector index=0. For a write, load the line register from sd_data_out. Go to REQ.
- REQ: rd (read) or wr (write) held high. In the cycle ready=1: beat counter cleared, go to XFER.
- XFER, read: each dout_valid shifts dout in at the MSB end of the line register.
- XFER, write: din = line register[DATA-1:0]; each din_ready shifts the register right by DATA.
- XFER, end of sector: on the beat that completes it (count = SECTOR_BYTES*8/DATA):
  - if sector index < SECTORS-1: ain+1, index+1, go to REQ directly (no idle cycle);
  - otherwise go to RESP.
- Byte order: first SD byte of the first sector is line bits [7:0]; after a read, sd_data_in holds the line in the same order.
- RESP: sd_valid_in=1 and sd_err_in valid, held until sd_ready_in. Then go to IDLE. Writes also respond (sd_data_in don't-care).
- Watchdog:
  - counter cleared on entering REQ, on each accepted beat, and in IDLE/RESP;
  - counts in REQ and XFER; reaching TIMEOUT forces RESP with sd_err_in=1;
  - the err flag clears when the next request is accepted;
  - after an abort the SD controller is not resynchronised here; the system recovers it.
- dout_valid/din_ready outside XFER are ignored; line register and counters are unchanged.
- Counter widths: beat $clog2(beats)+1, sector $clog2(SECTORS)+1, watchdog $clog2(TIMEOUT+1); no wrap inside legal ranges.

## Timing
- After reset: state IDLE; sd_ready_out=1, rd=wr=sd_valid_in=sd_err_in=0; ain=0; line register 0; all counters 0.
- rd/wr, sd_ready_out and sd_valid_in are decoded from the state register (no combinational input→output paths). din comes from the register.
- Request accept → rd/wr high next cycle.
- ready sampled with rd/wr high → XFER next cycle.
- Last beat → RESP or REQ next cycle.
- Read latency, zero-wait controller: 1 + SECTORS*(1 + beats) cycles from accept to sd_valid_in.
- A beat on the same cycle as a watchdog expiry: the beat counts and expiry is suppressed (progress wins).
- Reset mid-operation: returns to the reset state at the next edge regardless of state.

## Structure
- Package sdcard_pkg holds:
  - state enum (IDLE=0, REQ=1, XFER=2, RESP=3);
  - CMD_RD=0, CMD_WR=1;
  - default SECTOR_BYTES=512.
- Sub-module sdcard_line_shifter: WIDTH-bit register with parallel load, shift-out of DATA from the LSB end, and shift-in at the MSB end, parameters WIDTH/DATA. The FSM, counters and watchdog stay in the top.

## Test plan
- Read, SECTORS=1, DATA=8, addr 0x0000_0400, dout=0..255 repeated, no stalls → ain=2, rd high 1 cycle, sd_valid_in after 514 cycles, sd_data_in[7:0]=0x00, [15:8]=0x01, sd_err_in=0.
- Write, SECTORS=2, addr 0x0000_1000, line = incrementing bytes, din_ready every other cycle → wr twice with ain=8 then 9, din sequence 0x00..0xFF,0x00.., 1024 beats, one write response with err=0.
- Timeout, TIMEOUT=16: read request, ready held 0 → RESP exactly 16 cycles after entering REQ, sd_err_in=1; next request gives err=0.
- Back-pressure: sd_ready_in low 10 cycles in RESP → sd_valid_in and sd_data_in stable, sd_ready_out=0 throughout.
- Spurious beats: dout_valid/din_ready pulsed in IDLE and RESP → line register and ain unchanged.
- Reset mid-XFER at beat 100, then a fresh read → all outputs at reset values next cycle; the new read completes with correct data.
